pattern_tally: RTL and testbench

//  Downstream stage of the serial sequence detector: consumes its one-bit detect

---
 rtl/pattern_tally_if.sv | 34 +++
 rtl/pattern_tally.sv | 94 +++++++++
 tb/tb_pattern_tally.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_tally_if.sv
// Handshake bundle between the sequence detector, the pattern_tally stage and
// the readout consumer. The tally block uses the slave view; whatever drives
// hit/start/cnt_ready and takes the count uses the master view.
interface pattern_tally_if #(
    parameter int CNT_W = 8
);
    logic             hit;
    logic             start;
    logic             busy;
    logic [CNT_W-1:0] cnt_out;
    logic             cnt_valid;
    logic             cnt_ready;
    logic             ovf;

    modport master (
        output hit,
        output start,
        output cnt_ready,
        input  busy,
        input  cnt_out,
        input  cnt_valid,
        input  ovf
    );

    modport slave (
        input  hit,
        input  start,
        input  cnt_ready,
        output busy,
        output cnt_out,
        output cnt_valid,
        output ovf
    );
endinterface

// File: rtl/pattern_tally.sv
// pattern_tally: counts detector pulses over a fixed window of WIN_LEN clocks
// and hands the (saturating) count downstream over a valid/ready handshake.
// Optional build macro PATTERN_TALLY_EDGE_EN: count rising edges of hit
// instead of every cycle with hit high.
module pattern_tally #(
    parameter int CNT_W   = 8,
    parameter int WIN_LEN = 16
) (
    input  logic           clk,
    input  logic           rst,
    pattern_tally_if.slave bus
);
    localparam int WIN_W = $clog2(WIN_LEN);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] COUNT  = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ovf_reg;
    logic [WIN_W-1:0] win_cnt_reg;
    logic             inc;

`ifdef PATTERN_TALLY_EDGE_EN
    logic hit_q;

    // Previous-cycle hit, tracked in every state so a hit already high when
    // the window opens is not mistaken for a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= bus.hit;
        end
    end

    assign inc = bus.hit & ~hit_q;
`else
    assign inc = bus.hit;
`endif

    // Window FSM: arm on start, count for WIN_LEN cycles, hold result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            ovf_reg     <= 1'b0;
            win_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg   <= COUNT;
                        cnt_reg     <= '0;
                        ovf_reg     <= 1'b0;
                        win_cnt_reg <= '0;
                    end
                end
                COUNT: begin
                    if (inc) begin
                        if (cnt_reg == CNT_MAX) begin
                            ovf_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    // Last window cycle still counts; win_cnt parks at its max.
                    if (win_cnt_reg == WIN_LAST) begin
                        state_reg <= REPORT;
                    end else begin
                        win_cnt_reg <= win_cnt_reg + 1'b1;
                    end
                end
                REPORT: begin
                    if (bus.cnt_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.cnt_valid = (state_reg == REPORT);
    assign bus.cnt_out   = cnt_reg;
    assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_pattern_tally.sv
// Bench for pattern_tally: two instances (8-bit and 4-bit counters) share the
// same stimulus and are compared every cycle against a window-level model
// that derives counts from the recorded hit sequence of the current window.
module tb_pattern_tally;
    localparam int WIN_LEN = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hit = 1'b0;
    logic start = 1'b0;
    logic ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    pattern_tally_if #(.CNT_W(8)) bus8 ();
    pattern_tally_if #(.CNT_W(4)) bus4 ();

    assign bus8.hit = hit;
    assign bus8.start = start;
    assign bus8.cnt_ready = ready;
    assign bus4.hit = hit;
    assign bus4.start = start;
    assign bus4.cnt_ready = ready;

    pattern_tally #(.CNT_W(8), .WIN_LEN(WIN_LEN)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    pattern_tally #(.CNT_W(4), .WIN_LEN(WIN_LEN)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // phase: 0 = waiting for start, 1 = inside window, 2 = result on offer
    int m_phase = 0;
    bit win_hits[$];
    bit pre_hit = 1'b0;
    int n_windows = 0;

    // Number of counting events in the hits recorded so far for this window.
    function automatic int raw_count();
        int n = 0;
        for (int i = 0; i < win_hits.size(); i++) begin
`ifdef PATTERN_TALLY_EDGE_EN
            bit prev;
            prev = (i == 0) ? pre_hit : win_hits[i-1];
            if (win_hits[i] && !prev) n++;
`else
            if (win_hits[i]) n++;
`endif
        end
        return n;
    endfunction

    function automatic int exp_cnt(input int max_v);
        int r = raw_count();
        return (r > max_v) ? max_v : r;
    endfunction

    function automatic int exp_ovf(input int max_v);
        return (raw_count() > max_v) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        win_hits.delete();
        pre_hit = 1'b0;
    endtask

    // Advance the model by one clock using the inputs sampled on that edge.
    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    win_hits.delete();
                    pre_hit = hit;
                end
                1: begin
                    win_hits.push_back(hit);
                    if (win_hits.size() == WIN_LEN) m_phase = 2;
                end
                default: if (ready) begin
                    n_windows++;
                    $display("window %0d taken: cnt8=%0d ovf8=%0d cnt4=%0d ovf4=%0d",
                             n_windows, exp_cnt(255), exp_ovf(255), exp_cnt(15), exp_ovf(15));
                    m_phase = 0;
                end
            endcase
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One clock: model follows the edge, new inputs go on just after negedge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        chk("busy8", int'(bus8.busy), (m_phase != 0) ? 1 : 0);
        chk("valid8", int'(bus8.cnt_valid), (m_phase == 2) ? 1 : 0);
        chk("cnt8", int'(bus8.cnt_out), exp_cnt(255));
        chk("ovf8", int'(bus8.ovf), exp_ovf(255));
        chk("busy4", int'(bus4.busy), (m_phase != 0) ? 1 : 0);
        chk("valid4", int'(bus4.cnt_valid), (m_phase == 2) ? 1 : 0);
        chk("cnt4", int'(bus4.cnt_out), exp_cnt(15));
        chk("ovf4", int'(bus4.ovf), exp_ovf(15));
    end

    // Directed window: start for one cycle (hit low), hit = pat over the window,
    // then hold off cnt_ready for stall cycles while hit/start keep moving.
    task automatic run_window(input logic [WIN_LEN-1:0] pat, input int stall);
        start = 1'b1; hit = 1'b0; ready = 1'b0;
        cyc();
        start = 1'b0;
        for (int i = 0; i < WIN_LEN; i++) begin
            hit = pat[i];
            start = 1'(i % 2);
            if (i == WIN_LEN - 1) chk("latency_pre", int'(bus8.cnt_valid), 0);
            cyc();
        end
        chk("latency", int'(bus8.cnt_valid), 1);
        start = 1'b1;
        for (int i = 0; i < stall; i++) begin
            hit = ~hit;
            cyc();
            chk("stall_valid", int'(bus8.cnt_valid), 1);
        end
        ready = 1'b1; start = 1'b0; hit = 1'b0;
    endtask

    initial begin
        logic [WIN_LEN-1:0] pat;

        // Reset held with hit and start active
        hit = 1'b1; start = 1'b1; ready = 1'b1;
        cyc();
        cyc();
        chk("rst_busy", int'(bus8.busy), 0);
        chk("rst_valid", int'(bus8.cnt_valid), 0);
        chk("rst_cnt", int'(bus8.cnt_out), 0);
        chk("rst_ovf", int'(bus8.ovf), 0);
        rst = 1'b0; hit = 1'b0; start = 1'b0; ready = 1'b0;
        cyc();

        // Basic count: pulses on window cycles 1, 4, 8
        pat = '0; pat[1] = 1'b1; pat[4] = 1'b1; pat[8] = 1'b1;
        run_window(pat, 0);
        chk("basic_cnt", int'(bus8.cnt_out), 3);
        chk("basic_ovf", int'(bus8.ovf), 0);
        cyc();
        chk("basic_idle", int'(bus8.busy), 0);

        // Backpressure: six stalled cycles in REPORT
        run_window(pat, 6);
        chk("bp_cnt", int'(bus8.cnt_out), 3);
        cyc();
        chk("bp_idle", int'(bus8.busy), 0);
        chk("bp_hold", int'(bus8.cnt_out), 3);

        // Saturation on the 4-bit instance
        run_window({WIN_LEN{1'b1}}, 0);
`ifdef PATTERN_TALLY_EDGE_EN
        chk("sat_cnt4", int'(bus4.cnt_out), 1);
        chk("sat_ovf4", int'(bus4.ovf), 0);
`else
        chk("sat_cnt4", int'(bus4.cnt_out), 15);
        chk("sat_ovf4", int'(bus4.ovf), 1);
        chk("sat_cnt8", int'(bus8.cnt_out), 16);
`endif
        cyc();

        // Edge/level pattern 1,1,0,1,0,1,0,0,1,0,1,0
        pat = 16'b0000_0101_0010_1011;
        run_window(pat, 2);
`ifdef PATTERN_TALLY_EDGE_EN
        chk("pat_cnt", int'(bus8.cnt_out), 5);
`else
        chk("pat_cnt", int'(bus8.cnt_out), 6);
`endif
        cyc();
        ready = 1'b0;

        // Reset in the middle of a window
        start = 1'b1;
        cyc();
        start = 1'b0; hit = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_busy", int'(bus8.busy), 0);
        chk("midrst_cnt", int'(bus8.cnt_out), 0);
        chk("midrst_valid", int'(bus8.cnt_valid), 0);
        cyc();
        rst = 1'b0; ready = 1'b1;
        for (int i = 0; i < 20; i++) cyc();

        // Back-to-back: start held high, consumer always ready
        start = 1'b1; ready = 1'b1;
        for (int i = 0; i < 3 * (WIN_LEN + 2); i++) begin
            hit = 1'($urandom_range(0, 1));
            cyc();
        end

        // Randomized traffic with varying hit density and backpressure
        begin
            int dens = 50;
            for (int i = 0; i < 3000; i++) begin
                if (i % WIN_LEN == 0) dens = $urandom_range(0, 100);
                hit = 1'($urandom_range(0, 99) < dens);
                start = 1'($urandom_range(0, 3) != 0);
                ready = 1'($urandom_range(0, 2) == 0);
                cyc();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
